du_register_way1: RTL and testbench

Decode-to-execute pipeline register for way 1, placed between the way-1 decoder and the execute unit. Captures the decoded instruction bundle under a valid/ready handshake. A two-entry skid buffer gives the decoder a registered `ready_o` while sustaining one instruction per cycle. Supports a full pipeline flush and tags every entry with its 2-bit pipeline ID (`pID`) for downstream ordering.

---
 rtl/du_register_way1_if.sv | 46 ++++
 rtl/du_register_way1.sv | 138 +++++++++++++
 tb/tb_du_register_way1.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/du_register_way1_if.sv
// Decode-to-execute handshake bundle for way 1: decoder-side inputs, execute-side outputs.
// The slave modport is the pipeline register; the master modport is whoever drives it.
interface du_register_way1_if #(
    parameter int DATA_W = 64
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [4:0]        rdAddr_i;
    logic [4:0]        rdAddr_o;
    logic              rdWriteEnable_i;
    logic              rdWriteEnable_o;
    logic [DATA_W-1:0] rs1ReadData_i;
    logic [DATA_W-1:0] rs1ReadData_o;
    logic [DATA_W-1:0] rs2ReadData_i;
    logic [DATA_W-1:0] rs2ReadData_o;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_o;
    logic [6:0]        opCode_i;
    logic [6:0]        opCode_o;
    logic [2:0]        funct3_i;
    logic [2:0]        funct3_o;
    logic [6:0]        funct7_i;
    logic [6:0]        funct7_o;
    logic [5:0]        shamt_i;
    logic [5:0]        shamt_o;
    logic [1:0]        way1_pID_i;
    logic [1:0]        way1_pID_o;
    logic              valid_o;
    logic              ready_i;
    logic [1:0]        occupancy_o;

    modport slave (
        input  flush_i, valid_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
               imm_i, opCode_i, funct3_i, funct7_i, shamt_i, way1_pID_i, ready_i,
        output ready_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
               opCode_o, funct3_o, funct7_o, shamt_o, way1_pID_o, valid_o, occupancy_o
    );

    modport master (
        output flush_i, valid_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
               imm_i, opCode_i, funct3_i, funct7_i, shamt_i, way1_pID_i, ready_i,
        input  ready_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
               opCode_o, funct3_o, funct7_o, shamt_o, way1_pID_o, valid_o, occupancy_o
    );
endinterface

// File: rtl/du_register_way1.sv
// Way-1 decode-to-execute pipeline register: two-entry skid buffer with registered ready,
// full flush, and pID tag carried alongside each bundle.
//
// state | meaning
// EMPTY | no entry held, outputs zero
// ONE   | main entry valid, skid empty
// FULL  | main and skid valid, ready_o low
module du_register_way1 #(
    parameter int DATA_W = 64
) (
    input logic               clk,
    input logic               rst,
    du_register_way1_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]        rd_addr;
        logic              rd_we;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [6:0]        op_code;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [5:0]        shamt;
        logic [1:0]        pid;
    } payload_t;

    state_t   state_q, state_d;
    payload_t main_q, skid_q, in_payload;
    logic     ready_q;
    logic     main_valid, in_fire, out_fire;
    logic     load_main, load_skid, skid_to_main;

    assign in_payload = '{
        rd_addr:  bus.rdAddr_i,
        rd_we:    bus.rdWriteEnable_i,
        rs1_data: bus.rs1ReadData_i,
        rs2_data: bus.rs2ReadData_i,
        imm:      bus.imm_i,
        op_code:  bus.opCode_i,
        funct3:   bus.funct3_i,
        funct7:   bus.funct7_i,
        shamt:    bus.shamt_i,
        pid:      bus.way1_pID_i
    };

    assign main_valid = (state_q != EMPTY);
    assign in_fire    = bus.valid_i & ready_q;
    assign out_fire   = main_valid & bus.ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (bus.flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // ready_o is low here, so no input can arrive alongside the drain
                    if (out_fire) begin
                        state_d      = ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            ready_q <= (state_d != FULL);
            if (load_main) begin
                main_q <= in_payload;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_payload;
            end else if (skid_to_main || bus.flush_i) begin
                skid_q <= '0;
            end
        end
    end

    // Payload is zeroed whenever main is empty so stale data never reaches execute.
    assign bus.ready_o         = ready_q;
    assign bus.valid_o         = main_valid;
    assign bus.occupancy_o     = {state_q == FULL, state_q == ONE};
    assign bus.rdAddr_o        = main_valid ? main_q.rd_addr  : '0;
    assign bus.rdWriteEnable_o = main_valid & main_q.rd_we;
    assign bus.rs1ReadData_o   = main_valid ? main_q.rs1_data : '0;
    assign bus.rs2ReadData_o   = main_valid ? main_q.rs2_data : '0;
    assign bus.imm_o           = main_valid ? main_q.imm      : '0;
    assign bus.opCode_o        = main_valid ? main_q.op_code  : '0;
    assign bus.funct3_o        = main_valid ? main_q.funct3   : '0;
    assign bus.funct7_o        = main_valid ? main_q.funct7   : '0;
    assign bus.shamt_o         = main_valid ? main_q.shamt    : '0;
    assign bus.way1_pID_o      = main_valid ? main_q.pid      : '0;

endmodule

// File: tb/tb_du_register_way1.sv
// Directed bench for du_register_way1: stream, backpressure, drain, flush, write-enable
// masking and mid-stall reset, plus a monitor that outputs hold while stalled.
module tb_du_register_way1;

    localparam int DATA_W = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    du_register_way1_if #(.DATA_W(DATA_W)) bus ();

    du_register_way1 #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [63:0] imm, input logic [1:0] pid,
                         input logic we);
        bus.valid_i         = v;
        bus.imm_i           = imm;
        bus.way1_pID_i      = pid;
        bus.rdWriteEnable_i = we;
        bus.rdAddr_i        = imm[4:0];
        bus.rs1ReadData_i   = imm + 64'h100;
        bus.rs2ReadData_i   = imm + 64'h200;
        bus.opCode_i        = 7'h33;
        bus.funct3_i        = 3'h5;
        bus.funct7_i        = 7'h20;
        bus.shamt_i         = imm[5:0];
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [63:0] imm,
                              input logic [1:0] pid, input logic [1:0] occ, input logic rdy);
        check({tag, ".valid_o"}, 64'(bus.valid_o), 64'(v));
        check({tag, ".imm_o"}, bus.imm_o, imm);
        check({tag, ".pID_o"}, 64'(bus.way1_pID_o), 64'(pid));
        check({tag, ".occupancy_o"}, 64'(bus.occupancy_o), 64'(occ));
        check({tag, ".ready_o"}, 64'(bus.ready_o), 64'(rdy));
    endtask

    // Outputs must not change across an edge where valid_o=1 and ready_i=0.
    logic        hold_chk;
    logic [63:0] snap_imm;
    logic [63:0] snap_rs1;
    logic [1:0]  snap_pid;
    logic        snap_we;

    initial hold_chk = 1'b0;

    always @(posedge clk) begin
        hold_chk <= bus.valid_o & ~bus.ready_i & rst & ~bus.flush_i;
        snap_imm <= bus.imm_o;
        snap_rs1 <= bus.rs1ReadData_o;
        snap_pid <= bus.way1_pID_o;
        snap_we  <= bus.rdWriteEnable_o;
    end

    always @(negedge clk) begin
        if (hold_chk) begin
            check("stall_hold.imm_o", bus.imm_o, snap_imm);
            check("stall_hold.rs1_o", bus.rs1ReadData_o, snap_rs1);
            check("stall_hold.pID_o", 64'(bus.way1_pID_o), 64'(snap_pid));
            check("stall_hold.we_o", 64'(bus.rdWriteEnable_o), 64'(snap_we));
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        drive(1'b0, 64'h0, 2'd0, 1'b0);

        // reset held two cycles
        tick();
        tick();
        expect_out("reset", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);
        check("reset.we_o", 64'(bus.rdWriteEnable_o), 64'h0);
        check("reset.rs1_o", bus.rs1ReadData_o, 64'h0);
        rst = 1'b1;

        // stream 1..4 with ready_i=1
        drive(1'b1, 64'd1, 2'd0, 1'b1);
        check("stream.pre_valid_o", 64'(bus.valid_o), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i), 2'(i - 1), 1'b1);
            tick();
            expect_out($sformatf("stream%0d", i), 1'b1, 64'(i), 2'(i - 1), 2'd1, 1'b1);
            check($sformatf("stream%0d.rs2_o", i), bus.rs2ReadData_o, 64'(i) + 64'h200);
        end
        drive(1'b0, 64'h0, 2'd0, 1'b0);
        tick();
        expect_out("stream_end", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);

        // backpressure: A in main, B absorbed into skid
        drive(1'b1, 64'hA, 2'd1, 1'b1);
        tick();
        expect_out("bp_a", 1'b1, 64'hA, 2'd1, 2'd1, 1'b1);
        check("bp_a.we_o", 64'(bus.rdWriteEnable_o), 64'h1);
        check("bp_a.rdAddr_o", 64'(bus.rdAddr_o), 64'hA);
        bus.ready_i = 1'b0;
        drive(1'b1, 64'hB, 2'd2, 1'b0);
        tick();
        expect_out("bp_fill", 1'b1, 64'hA, 2'd1, 2'd2, 1'b0);
        // C offered while full must be ignored
        drive(1'b1, 64'hC, 2'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("bp_stall%0d", i), 1'b1, 64'hA, 2'd1, 2'd2, 1'b0);
        end

        // drain: A already shown, B next, then empty
        drive(1'b0, 64'h0, 2'd0, 1'b0);
        bus.ready_i = 1'b1;
        tick();
        expect_out("drain_b", 1'b1, 64'hB, 2'd2, 2'd1, 1'b1);
        check("drain_b.we_o", 64'(bus.rdWriteEnable_o), 64'h0);
        tick();
        expect_out("drain_empty", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);

        // flush from FULL with a simultaneous input
        drive(1'b1, 64'h11, 2'd0, 1'b1);
        tick();
        bus.ready_i = 1'b0;
        drive(1'b1, 64'h22, 2'd1, 1'b1);
        tick();
        expect_out("flush_pre", 1'b1, 64'h11, 2'd0, 2'd2, 1'b0);
        bus.flush_i = 1'b1;
        drive(1'b1, 64'hDEAD, 2'd3, 1'b1);
        tick();
        expect_out("flush", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);
        bus.flush_i = 1'b0;
        drive(1'b0, 64'h0, 2'd0, 1'b0);
        bus.ready_i = 1'b1;
        tick();
        expect_out("flush_after", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);

        // write-enable masking with no valid input
        drive(1'b0, 64'h5, 2'd1, 1'b1);
        tick();
        check("we_mask.we_o", 64'(bus.rdWriteEnable_o), 64'h0);
        check("we_mask.valid_o", 64'(bus.valid_o), 64'h0);

        // reset mid-stall from FULL
        drive(1'b1, 64'h33, 2'd1, 1'b1);
        tick();
        bus.ready_i = 1'b0;
        drive(1'b1, 64'h44, 2'd3, 1'b1);
        tick();
        expect_out("rst_pre", 1'b1, 64'h33, 2'd1, 2'd2, 1'b0);
        drive(1'b0, 64'h0, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("rst_mid", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);
        check("rst_mid.we_o", 64'(bus.rdWriteEnable_o), 64'h0);
        rst = 1'b1;
        bus.ready_i = 1'b1;
        drive(1'b1, 64'h77, 2'd2, 1'b1);
        tick();
        expect_out("rst_next", 1'b1, 64'h77, 2'd2, 2'd1, 1'b1);
        drive(1'b0, 64'h0, 2'd0, 1'b0);
        tick();
        expect_out("rst_next_end", 1'b0, 64'h0, 2'd0, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
